song_sequencer: RTL and testbench
=================================

SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 Parameter STEPS, default 64: number of sequence steps (chord and duration RAM depth).
REQ-002 Parameter TICK_DIV, default 50000: CLK cycles per tempo tick (1 ms at 50 MHz).
REQ-003 Parameter GAP_TICKS, default 1: silent ticks inserted after each step.
REQ-004 CLK  in  1  system clock; all logic is on its rising edge.
REQ-005 RESET  in  1  reset; asynchronous, active-high.
REQ-006 chord_address  in  6  chord RAM index.
REQ-007 chord_write  in  1  chord RAM write strobe.
REQ-008 chord_writedata  in  32  four 8-bit keycodes; 0x00 means empty slot.
REQ-009 chord_readdata  out  32  combinational read of chord RAM at chord_address.
REQ-010 dur_address  in  6  duration RAM index.
REQ-011 dur_write  in  1  duration RAM write strobe.
REQ-012 dur_writedata  in  16  step duration in ticks; 0 marks end of sequence.
REQ-013 dur_readdata  out  16  combinational read of duration RAM at dur_address.
REQ-014 ctrl_write  in  1  control write strobe.
REQ-015 ctrl_writedata  in  32  bit0 play, bit1 loop, bits[13:8] last step index.
REQ-016 ctrl_readdata  out  32  bit0 busy, bit1 loop, bits[13:8] last, bit16 done, bits[21:16+...] n/a, bits[29:24] current step.
REQ-017 song  out  32  registered chord word driven to the synthesizer song input.

Function
REQ-018 FSM states: IDLE, LOAD, PLAY, GAP, DONE; busy = state in {LOAD, PLAY, GAP}.
REQ-019 ctrl_write always latches loop and last; bit0 is acted on per REQ-020..022.
REQ-020 ctrl_write with bit0=1 in IDLE or DONE: step<=0, done<=0, next state LOAD.
REQ-021 ctrl_write with bit0=1 while busy: no restart; step and state unchanged.
REQ-022 ctrl_write with bit0=0 in any state: next state IDLE, step<=0, song<=0 on the same edge.
REQ-023 Tick generator counts 0..TICK_DIV-1 only while busy, emitting a 1-cycle tick at TICK_DIV-1; it is cleared on entry to LOAD and in IDLE/DONE.
REQ-024 LOAD (one cycle): if dur[step]==0, treat as end (REQ-027); else remaining<=dur[step], song<=chord[step], go to PLAY.
REQ-025 PLAY: on tick remaining decrements; a tick with remaining==1 sets song<=0, gap<=GAP_TICKS, and goes to GAP.
REQ-026 GAP: on tick gap decrements; a tick with gap==1 ends the step: if step>=last, end (REQ-027); else step<=step+1 and go to LOAD.
REQ-027 End: if loop=1, step<=0 and go to LOAD; else done<=1, song<=0, go to DONE.
REQ-028 step wraps from STEPS-1 to 0 only through REQ-027; last is compared at GAP exit, so lowering last mid-play takes effect at the next step end.
REQ-029 A ctrl_write in the same cycle as a tick takes priority; the tick is discarded.
REQ-030 RAM writes are allowed while busy and take effect at that step's next LOAD; song is never altered by RAM writes.
REQ-031 A same-cycle RAM write and LOAD read of one address returns the old data.
REQ-032 song changes at most once per tick period and holds at least one tick, so an asynchronous LRCLK-domain consumer samples it stably; the GAP guarantees release and retrigger of repeated notes.
REQ-033 Latency: song is valid 2 CLK cycles after a play ctrl_write (ctrl->LOAD->PLAY).

Reset
REQ-034 RESET clears chord RAM, duration RAM, loop, last, step, remaining, gap, the tick counter, done, and song to 0, and sets state to IDLE.
REQ-035 RESET mid-play forces song=0 immediately, without waiting for a clock edge.

Structure
REQ-036 Package song_seq_pkg holds the state enum, ctrl bit-position constants, and STEPS/TICK_DIV defaults.
REQ-037 Sub-module tempo_tick (counter plus clear/enable, tick output); all other logic lives in song_sequencer.

Verification (TICK_DIV=4, GAP_TICKS=1)
REQ-038 chord0=0x00000014, dur0=3, dur1=0, ctrl=0x001 -> song=0x14 for 12 cycles, then 0 for 4 cycles, then DONE with done=1.
REQ-039 Steps 0..2 with dur=2, last=2, loop=1 -> chords 0,1,2,0 in order, with one silent tick between them; busy stays 1.
REQ-040 Stop (ctrl=0x000) mid-PLAY -> song=0 on the next edge, state IDLE, step=0; re-play starts again at step 0.
REQ-041 ctrl_write coincident with a tick while remaining==1 -> the tick is ignored and remaining stays 1.
REQ-042 Assert RESET during PLAY -> song=0 asynchronously, and chord_readdata/dur_readdata read 0 at all addresses.
REQ-043 Rewrite chord1 while step 0 plays -> the new value appears at step 1 LOAD, and step 0's output is unchanged.

Source files
------------

// File: rtl/song_seq_pkg.sv
// Shared definitions for the song sequencer.
//   - state_t           : sequencer FSM states
//   - CTRL_* / STAT_*   : bit positions in the control write word and status read word
//   - DEFAULT_*         : default values for the sequencer parameters
//   - addr_in_range()   : true when a RAM index falls inside the configured depth
package song_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam int STEP_W        = 6;

  // Control write word.
  localparam int CTRL_PLAY     = 0;
  localparam int CTRL_LOOP     = 1;
  localparam int CTRL_LAST_LSB = 8;

  // Status read word. The loop and last fields sit in the same positions as in the write word.
  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 16;
  localparam int STAT_STEP_LSB = 24;

  localparam int DEFAULT_STEPS     = 64;
  localparam int DEFAULT_TICK_DIV  = 50000;
  localparam int DEFAULT_GAP_TICKS = 1;

  function automatic logic addr_in_range(input logic [STEP_W-1:0] addr, input int depth);
    return int'(addr) < depth;
  endfunction

endpackage

// File: rtl/song_sequencer_tempo_tick.sv
// Tempo tick generator.
// Counts 0..TICK_DIV-1 while enabled and raises a one-cycle tick on the
// last count. A clear forces the count back to zero.
//   CLK    : system clock
//   RESET  : asynchronous, active-high reset
//   clear  : hold the counter at zero
//   enable : allow counting
//   tick   : one-cycle pulse at count TICK_DIV-1
module tempo_tick
  import song_seq_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST_CNT) ? '0 : count + 1'b1;
    end
  end

  // Not gated by clear: clear is derived from state only, which keeps the
  // tick -> next-state path free of combinational loops.
  assign tick = enable && (count == LAST_CNT);

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: steps through a table of chords, holding each for a
// programmed number of tempo ticks, then inserting a silent gap so that
// repeated notes are released and retriggered.
//   CLK, RESET            : clock, asynchronous active-high reset
//   chord_address/write/
//   chord_writedata       : chord RAM port (four 8-bit keycodes per word)
//   chord_readdata        : combinational chord RAM read
//   dur_address/write/
//   dur_writedata         : duration RAM port (ticks, 0 = end of sequence)
//   dur_readdata          : combinational duration RAM read
//   ctrl_write/writedata  : bit0 play, bit1 loop, [13:8] last step
//   ctrl_readdata         : bit0 busy, bit1 loop, [13:8] last, bit16 done, [29:24] step
//   song                  : registered chord word to the synthesizer
module song_sequencer
  import song_seq_pkg::*;
#(
  parameter int STEPS     = DEFAULT_STEPS,
  parameter int TICK_DIV  = DEFAULT_TICK_DIV,
  parameter int GAP_TICKS = DEFAULT_GAP_TICKS
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [5:0]  chord_address,
  input  logic        chord_write,
  input  logic [31:0] chord_writedata,
  output logic [31:0] chord_readdata,
  input  logic [5:0]  dur_address,
  input  logic        dur_write,
  input  logic [15:0] dur_writedata,
  output logic [15:0] dur_readdata,
  input  logic        ctrl_write,
  input  logic [31:0] ctrl_writedata,
  output logic [31:0] ctrl_readdata,
  output logic [31:0] song
);

  localparam logic [15:0] GAP_INIT = 16'(GAP_TICKS);

  logic [31:0] chord_ram [STEPS];
  logic [15:0] dur_ram   [STEPS];

  state_t            state, next_state, end_state;
  logic              loop, done, busy, tick, tick_clear;
  logic [STEP_W-1:0] last, step;
  logic [15:0]       remaining, gap;
  logic              start, stop, eff_tick;
  logic              load_end, play_end, gap_end, seq_end;
  logic              ctrl_unused;

  assign ctrl_unused = ^{ctrl_writedata[31:14], ctrl_writedata[7:2]};

  // ---------------- RAMs ----------------
  // NOTE: both RAMs are cleared by reset, so they are built from resettable flops.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < STEPS; i++) begin
        chord_ram[i] <= '0;
        dur_ram[i]   <= '0;
      end
    end else begin
      if (chord_write && addr_in_range(chord_address, STEPS))
        chord_ram[chord_address] <= chord_writedata;
      if (dur_write && addr_in_range(dur_address, STEPS))
        dur_ram[dur_address] <= dur_writedata;
    end
  end

  assign chord_readdata = addr_in_range(chord_address, STEPS) ? chord_ram[chord_address] : '0;
  assign dur_readdata   = addr_in_range(dur_address, STEPS)   ? dur_ram[dur_address]     : '0;

  // ---------------- tempo ----------------
  tempo_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK    (CLK),
    .RESET  (RESET),
    .clear  (tick_clear),
    .enable (busy),
    .tick   (tick)
  );

  // ---------------- decoded events ----------------
  assign stop      = ctrl_write && !ctrl_writedata[CTRL_PLAY];
  assign start     = ctrl_write &&  ctrl_writedata[CTRL_PLAY] &&
                     (state == ST_IDLE || state == ST_DONE);
  // A control write in the same cycle swallows the tick.
  assign eff_tick  = tick && !ctrl_write;
  assign load_end  = (state == ST_LOAD) && (dur_ram[step] == 16'd0);
  assign play_end  = (state == ST_PLAY) && eff_tick && (remaining == 16'd1);
  assign gap_end   = (state == ST_GAP)  && eff_tick && (gap == 16'd1);
  // last is only consulted when a step finishes its gap.
  assign seq_end   = load_end || (gap_end && (step >= last));
  assign end_state = loop ? ST_LOAD : ST_DONE;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= next_state;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
    next_state = state;
    if (stop) begin
      next_state = ST_IDLE;
    end else if (start) begin
      next_state = ST_LOAD;
    end else begin
      case (state)
        ST_LOAD: next_state = load_end ? end_state : ST_PLAY;
        ST_PLAY: if (play_end) next_state = ST_GAP;
        ST_GAP:  if (gap_end)  next_state = seq_end ? end_state : ST_LOAD;
        default: ;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy       = (state == ST_LOAD) || (state == ST_PLAY) || (state == ST_GAP);
    // Counter restarts from zero for every LOAD and stays idle outside a song.
    tick_clear = !((state == ST_PLAY) || (state == ST_GAP));
    ctrl_readdata                            = '0;
    ctrl_readdata[STAT_BUSY]                 = busy;
    ctrl_readdata[CTRL_LOOP]                 = loop;
    ctrl_readdata[CTRL_LAST_LSB +: STEP_W]   = last;
    ctrl_readdata[STAT_DONE]                 = done;
    ctrl_readdata[STAT_STEP_LSB +: STEP_W]   = step;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      loop      <= 1'b0;
      last      <= '0;
      step      <= '0;
      remaining <= '0;
      gap       <= '0;
      done      <= 1'b0;
      song      <= '0;
    end else begin
      if (ctrl_write) begin
        loop <= ctrl_writedata[CTRL_LOOP];
        last <= ctrl_writedata[CTRL_LAST_LSB +: STEP_W];
      end

      if (stop) begin
        step <= '0;
        song <= '0;
      end else if (start) begin
        step <= '0;
        done <= 1'b0;
      end else begin
        if (state == ST_LOAD && !load_end) begin
          remaining <= dur_ram[step];
          song      <= chord_ram[step];
        end
        if (state == ST_PLAY && eff_tick) begin
          remaining <= remaining - 16'd1;
          if (play_end) begin
            song <= '0;
            gap  <= GAP_INIT;
          end
        end
        if (state == ST_GAP && eff_tick) begin
          gap <= gap - 16'd1;
          if (gap_end && !seq_end) step <= step + 1'b1;
        end
        if (seq_end) begin
          if (loop) begin
            step <= '0;
          end else begin
            done <= 1'b1;
            song <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed testbench for song_sequencer with TICK_DIV=4, GAP_TICKS=1.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_song_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [5:0]  chord_address;
  logic        chord_write;
  logic [31:0] chord_writedata;
  logic [31:0] chord_readdata;
  logic [5:0]  dur_address;
  logic        dur_write;
  logic [15:0] dur_writedata;
  logic [15:0] dur_readdata;
  logic        ctrl_write;
  logic [31:0] ctrl_writedata;
  logic [31:0] ctrl_readdata;
  logic [31:0] song;

  int errors = 0;
  int checks = 0;

  song_sequencer #(.STEPS(64), .TICK_DIV(4), .GAP_TICKS(1)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .chord_address   (chord_address),
    .chord_write     (chord_write),
    .chord_writedata (chord_writedata),
    .chord_readdata  (chord_readdata),
    .dur_address     (dur_address),
    .dur_write       (dur_write),
    .dur_writedata   (dur_writedata),
    .dur_readdata    (dur_readdata),
    .ctrl_write      (ctrl_write),
    .ctrl_writedata  (ctrl_writedata),
    .ctrl_readdata   (ctrl_readdata),
    .song            (song)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Each write task is entered on a falling edge and returns on the next one,
  // so the strobe is seen by exactly one rising edge.
  task automatic write_chord(input logic [5:0] a, input logic [31:0] d);
    chord_address = a; chord_writedata = d; chord_write = 1'b1;
    @(negedge CLK);
    chord_write = 1'b0;
  endtask

  task automatic write_dur(input logic [5:0] a, input logic [15:0] d);
    dur_address = a; dur_writedata = d; dur_write = 1'b1;
    @(negedge CLK);
    dur_write = 1'b0;
  endtask

  task automatic write_ctrl(input logic [31:0] d);
    ctrl_writedata = d; ctrl_write = 1'b1;
    @(negedge CLK);
    ctrl_write = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    chord_address = '0; chord_write = 1'b0; chord_writedata = '0;
    dur_address = '0;   dur_write = 1'b0;   dur_writedata = '0;
    ctrl_write = 1'b0;  ctrl_writedata = '0;

    // ---- reset state ----
    cyc(2);
    check("reset_song", song, 32'h0);
    check("reset_ctrl", ctrl_readdata, 32'h0);
    check("reset_chord0", chord_readdata, 32'h0);
    RESET = 1'b0;
    cyc(1);

    // ---- single step, no loop: 12 cycles of chord, 4 silent, then DONE ----
    write_chord(6'd0, 32'h0000_0014);
    write_dur(6'd0, 16'd3);
    write_dur(6'd1, 16'd0);
    write_ctrl(32'h0000_0001);                     // edge E0: IDLE -> LOAD
    check("one_load_song", song, 32'h0);
    check("one_load_busy", ctrl_readdata, 32'h0000_0001);
    for (int i = 0; i < 12; i++) begin             // after E1..E12
      cyc(1);
      check($sformatf("one_hold_%0d", i), song, 32'h0000_0014);
    end
    cyc(1);                                        // after E13
    check("one_gap_song", song, 32'h0);
    cyc(3);                                        // after E16
    check("one_gap_busy", {31'b0, ctrl_readdata[0]}, 32'h1);
    cyc(1);                                        // after E17
    check("one_done", ctrl_readdata, 32'h0001_0000);
    check("one_done_song", song, 32'h0);

    // ---- three steps looping, dur=2 each: 13-cycle step period ----
    write_chord(6'd0, 32'h0000_0011);
    write_chord(6'd1, 32'h0000_0022);
    write_chord(6'd2, 32'h0000_0033);
    write_dur(6'd0, 16'd2);
    write_dur(6'd1, 16'd2);
    write_dur(6'd2, 16'd2);
    write_ctrl(32'h0000_0203);                     // E0
    cyc(1);
    check("loop_step0", song, 32'h0000_0011);      // E1
    cyc(8);
    check("loop_gap0_song", song, 32'h0);          // E9
    check("loop_gap0_busy", {31'b0, ctrl_readdata[0]}, 32'h1);
    cyc(5);
    check("loop_step1", song, 32'h0000_0022);      // E14
    cyc(13);
    check("loop_step2", song, 32'h0000_0033);      // E27
    cyc(13);
    check("loop_wrap", song, 32'h0000_0011);       // E40
    check("loop_wrap_ctrl", ctrl_readdata, 32'h0000_0203);
    cyc(13);
    check("loop_step1b", song, 32'h0000_0022);     // E53
    check("loop_step1b_ctrl", ctrl_readdata, 32'h0100_0203);

    // ---- stop mid-play, then replay from step 0 ----
    write_ctrl(32'h0000_0000);
    check("stop_song", song, 32'h0);
    check("stop_ctrl", ctrl_readdata, 32'h0);
    write_ctrl(32'h0000_0203);                     // E0
    cyc(1);
    check("replay_step0", song, 32'h0000_0011);    // E1

    // ---- control write coincident with the tick at remaining==1 ----
    cyc(7);                                        // after E8
    write_ctrl(32'h0000_0203);                     // lands on the E9 tick
    check("tick_drop_e9", song, 32'h0000_0011);
    check("tick_drop_busy", ctrl_readdata, 32'h0000_0203);
    cyc(3);
    check("tick_drop_e12", song, 32'h0000_0011);
    cyc(1);
    check("tick_drop_e13", song, 32'h0);
    cyc(5);
    check("tick_drop_next", song, 32'h0000_0022);  // E18

    // ---- RAM rewrites while playing ----
    write_ctrl(32'h0000_0000);
    write_ctrl(32'h0000_0203);                     // E0
    cyc(1);
    check("rw_step0", song, 32'h0000_0011);        // E1
    write_chord(6'd1, 32'h0000_5566);              // E2
    check("rw_song_kept", song, 32'h0000_0011);
    check("rw_readback", chord_readdata, 32'h0000_5566);
    cyc(12);
    check("rw_step1_new", song, 32'h0000_5566);    // E14
    cyc(12);                                       // after E26, step 2 in LOAD
    write_chord(6'd2, 32'h0000_0077);              // same edge as the LOAD read
    check("rw_same_edge_old", song, 32'h0000_0033);
    check("rw_same_edge_ram", chord_readdata, 32'h0000_0077);

    // ---- asynchronous reset during PLAY ----
    cyc(3);
    check("areset_pre", song, 32'h0000_0033);
    #2 RESET = 1'b1;
    #1 check("areset_song", song, 32'h0);
    check("areset_ctrl", ctrl_readdata, 32'h0);
    for (int a = 0; a < 64; a += 21) begin
      chord_address = 6'(a);
      dur_address   = 6'(a);
      #1;
      check($sformatf("areset_chord_%0d", a), chord_readdata, 32'h0);
      check($sformatf("areset_dur_%0d", a), {16'b0, dur_readdata}, 32'h0);
    end
    @(negedge CLK);
    RESET = 1'b0;
    cyc(1);

    // ---- zero duration at step 1 ends a non-looping sequence early ----
    write_chord(6'd0, 32'h0000_0099);
    write_dur(6'd0, 16'd2);
    write_ctrl(32'h0000_0501);                     // last=5, loop=0
    cyc(1);
    check("zero_step0", song, 32'h0000_0099);      // E1
    cyc(12);
    check("zero_load1", ctrl_readdata, 32'h0100_0501); // E13
    cyc(1);
    check("zero_done", ctrl_readdata, 32'h0101_0500);  // E14
    check("zero_song", song, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
